// File: rtl/apu_pkg.sv
// Purpose: shared APU timing constants, the frame-step state type and the
//          prescale helper used by the frame sequencer and the rate timers.
// Contents: MODE_4STEP/MODE_5STEP, STEPS_4/STEPS_5, step_e, frame_prescale().
package apu_pkg;

  localparam logic MODE_4STEP = 1'b0;
  localparam logic MODE_5STEP = 1'b1;

  localparam int unsigned STEPS_4 = 4;
  localparam int unsigned STEPS_5 = 5;

  typedef enum logic [2:0] {
    STEP0 = 3'd0,
    STEP1 = 3'd1,
    STEP2 = 3'd2,
    STEP3 = 3'd3,
    STEP4 = 3'd4
  } step_e;

  // Number of system clocks per frame tick (integer divide).
  function automatic int unsigned frame_prescale(input int unsigned clkrate,
                                                 input int unsigned hz);
    return clkrate / hz;
  endfunction

endpackage

// File: rtl/clk_prescaler.sv
// Purpose: free-running down-counter that emits a one-cycle tick every
//          PRESCALE clocks. Shared by the frame sequencer and rate timers.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (reloads the counter)
//   restart  in   reload the counter to PRESCALE-1 this edge
//   tick     out  high for the single cycle in which the counter is 0
module clk_prescaler #(
  parameter int unsigned PRESCALE = 20,
  parameter int unsigned PSW      = $clog2(PRESCALE)
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  logic [PSW-1:0] r_cnt;

  // Tick is decoded from the count so it lines up with the reload cycle.
  assign tick = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_cnt <= PSW'(PRESCALE - 1);
    end else if (r_cnt == '0) begin
      r_cnt <= PSW'(PRESCALE - 1);
    end else begin
      r_cnt <= r_cnt - PSW'(1);
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Purpose: APU frame sequencer. Divides clk to the frame-tick rate, walks a
//          4- or 5-step sequence and emits quarter/half-frame pulses plus a
//          latched frame IRQ.
// Ports:
//   clk              in   system clock
//   rst              in   synchronous active-high reset
//   cfg_we           in   frame-counter register write strobe
//   cfg_mode         in   0 = 4-step, 1 = 5-step (sampled on cfg_we)
//   cfg_irq_inhibit  in   1 = frame IRQ disabled (sampled on cfg_we)
//   irq_ack          in   clear frame IRQ
//   quarter_frame    out  one-cycle envelope/linear-counter pulse
//   half_frame       out  one-cycle length/sweep pulse
//   frame_irq        out  latched frame IRQ level
//   step             out  current sequence index 0..4
module frame_sequencer
  import apu_pkg::*;
#(
  parameter int unsigned CLKRATE  = 1_790_000,
  parameter int unsigned FRAME_HZ = 240,
  parameter int unsigned PSW      = $clog2(frame_prescale(CLKRATE, FRAME_HZ))
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_we,
  input  logic       cfg_mode,
  input  logic       cfg_irq_inhibit,
  input  logic       irq_ack,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq,
  output logic [2:0] step
);

  localparam int unsigned PRESCALE = frame_prescale(CLKRATE, FRAME_HZ);

  step_e r_step;
  logic  r_mode;
  logic  r_irq_inhibit;
  logic  r_quarter;
  logic  r_half;
  logic  r_irq;

  logic  w_tick;
  logic  w_quarter;
  logic  w_half;
  logic  w_irq_set;
  step_e w_next_step;

  clk_prescaler #(
    .PRESCALE (PRESCALE),
    .PSW      (PSW)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .restart (cfg_we),
    .tick    (w_tick)
  );

  // Action decode for the current step; unreachable indices fall back to
  // the wrap step so 4-step mode can never run past step 3.
  always_comb begin
    w_quarter   = 1'b0;
    w_half      = 1'b0;
    w_irq_set   = 1'b0;
    w_next_step = r_step;
    if (r_mode == MODE_4STEP) begin
      case (r_step)
        STEP0:   begin w_quarter = 1'b1; w_next_step = STEP1; end
        STEP1:   begin w_quarter = 1'b1; w_half = 1'b1; w_next_step = STEP2; end
        STEP2:   begin w_quarter = 1'b1; w_next_step = STEP3; end
        default: begin
          w_quarter   = 1'b1;
          w_half      = 1'b1;
          w_irq_set   = ~r_irq_inhibit;
          w_next_step = STEP0;
        end
      endcase
    end else begin
      case (r_step)
        STEP0:   begin w_quarter = 1'b1; w_next_step = STEP1; end
        STEP1:   begin w_quarter = 1'b1; w_half = 1'b1; w_next_step = STEP2; end
        STEP2:   begin w_quarter = 1'b1; w_next_step = STEP3; end
        STEP3:   begin w_next_step = STEP4; end
        default: begin w_quarter = 1'b1; w_half = 1'b1; w_next_step = STEP0; end
      endcase
    end
  end

  // Sequencer state, pulse registers and IRQ latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step        <= STEP0;
      r_mode        <= MODE_4STEP;
      r_irq_inhibit <= 1'b0;
      r_quarter     <= 1'b0;
      r_half        <= 1'b0;
      r_irq         <= 1'b0;
    end else if (cfg_we) begin
      // A write restarts the sequence and swallows any coincident tick;
      // 5-step mode clocks the units immediately.
      r_mode        <= cfg_mode;
      r_irq_inhibit <= cfg_irq_inhibit;
      r_step        <= STEP0;
      r_quarter     <= cfg_mode;
      r_half        <= cfg_mode;
      if (cfg_irq_inhibit || irq_ack) begin
        r_irq <= 1'b0;
      end
    end else begin
      r_quarter <= 1'b0;
      r_half    <= 1'b0;
      if (w_tick) begin
        r_quarter <= w_quarter;
        r_half    <= w_half;
        r_step    <= w_next_step;
      end
      // Set beats acknowledge.
      if (w_tick && w_irq_set) begin
        r_irq <= 1'b1;
      end else if (irq_ack) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign quarter_frame = r_quarter;
  assign half_frame    = r_half;
  assign frame_irq     = r_irq;
  assign step          = r_step;

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Parametrised audio frame sequencer: the successor to the fixed 240 Hz/120 Hz enable generator.
- Divides the system clock to a programmable frame-tick rate and walks a 4-step or 5-step sequence.
- Emits quarter-frame pulses (envelope/linear counter) and half-frame pulses (length/sweep), plus a latched frame IRQ.
- Sits between the CPU register interface and the channel envelope/length/sweep units.

Parameters:
- CLKRATE, 1_790_000, system clock rate in Hz.
- FRAME_HZ, 240, frame-tick rate in Hz. PRESCALE = CLKRATE/FRAME_HZ, integer divide; PRESCALE >= 2 is required.
- PSW, $clog2(CLKRATE/FRAME_HZ), prescaler width (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cfg_we  in  1  one-cycle write strobe for the frame-counter register.
- cfg_mode  in  1  sampled on cfg_we: 0 = 4-step, 1 = 5-step.
- cfg_irq_inhibit  in  1  sampled on cfg_we: 1 = frame IRQ disabled.
- irq_ack  in  1  one-cycle clear of the frame IRQ (status read).
- quarter_frame  out  1  one-cycle pulse.
- half_frame  out  1  one-cycle pulse.
- frame_irq  out  1  level; latched until cleared.
- step  out  3  current sequence index, 0..4.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - prescaler <= PRESCALE-1; step <= 0; mode <= 0; irq_inhibit <= 0.
  - quarter_frame, half_frame and frame_irq <= 0.
  - rst overrides every other input.
- Prescaler: decrements each clk. At 0 it reloads PRESCALE-1 and asserts internal tick for that cycle. The tick period is exactly PRESCALE clocks.
- On tick, the sequencer acts on the current step, then advances:
  - 4-step mode: wraps 3 -> 0.
  - 5-step mode: wraps 4 -> 0.
- Action table by current step:
  - 4-step, step 0: quarter.
  - 4-step, step 1: quarter and half.
  - 4-step, step 2: quarter.
  - 4-step, step 3: quarter and half; set frame_irq if irq_inhibit=0.
  - 5-step, step 0: quarter.
  - 5-step, step 1: quarter and half.
  - 5-step, step 2: quarter.
  - 5-step, step 3: none.
  - 5-step, step 4: quarter and half. 5-step mode never sets the IRQ.
- Output timing:
  - quarter_frame and half_frame are registered and high for exactly one cycle.
  - They assert in the cycle after the tick cycle (latency 1).
  - step updates at the same edge as the pulses.
- Register write (cfg_we=1):
  - mode <= cfg_mode; irq_inhibit <= cfg_irq_inhibit.
  - prescaler <= PRESCALE-1; step <= 0.
  - Any tick in the same cycle is discarded: no pulse, no IRQ set.
  - If cfg_mode=1, quarter_frame and half_frame pulse on the next cycle (immediate clock).
  - If cfg_irq_inhibit=1, frame_irq clears at the same edge.
- IRQ priority: set > irq_ack > hold.
  - A set and irq_ack in the same cycle leaves frame_irq=1.
  - cfg_we with inhibit=1 clears frame_irq regardless of irq_ack.
- Mode change mid-sequence happens only through cfg_we, which restarts at step 0.
- step never exceeds 3 in 4-step mode.
- Reset mid-sequence: all state returns to reset values at that edge, and no pulse is emitted on the following cycle.

Decomposition:
- Shared package apu_pkg:
  - MODE_4STEP=1'b0 and MODE_5STEP=1'b1.
  - Step-count constants 4 and 5.
  - Function frame_prescale(clkrate, hz).
- One natural sub-module, clk_prescaler:
  - Parameters PRESCALE and PSW.
  - Inputs clk, rst, restart; output tick.
  - Reusable by the DMC and noise-rate timers.
- The sequencer FSM (step register, action decode, IRQ latch) stays in frame_sequencer.

Test Plan:
- CLKRATE=4800, FRAME_HZ=240 (PRESCALE=20), release reset:
  - quarter_frame pulses at cycles 20, 40, 60, 80 after the first tick alignment.
  - half_frame pulses on the 2nd and 4th quarter pulses.
  - frame_irq rises with the 4th pulse; step sequence 1, 2, 3, 0.
- Same setup, cfg_we with mode=1, inhibit=0:
  - quarter_frame and half_frame pulse on the next cycle.
  - Over 5 ticks, quarter appears on 4 ticks and half on 2; tick 4 is silent.
  - frame_irq stays 0 for 200 cycles.
- 4-step with inhibit=1: no frame_irq over 10 ticks. Then cfg_we with inhibit=0: frame_irq sets at step 3 of the new sequence.
- frame_irq=1, then irq_ack: frame_irq=0 next cycle. irq_ack asserted in the same cycle as a step-3 tick: frame_irq remains 1.
- cfg_we asserted in the exact cycle prescaler==0: no pulse from that tick, step=0, next tick 20 cycles later.
- rst=1 for one cycle mid-sequence while frame_irq=1:
  - All outputs 0 next cycle, step=0.
  - First quarter_frame arrives exactly PRESCALE+1 cycles after reset deassertion.
